// File: rtl/mnist_img_loader.sv
// mnist_img_loader: packs a strobed byte stream into a binarized IMG_W x IMG_H pixel buffer; define MNIST_LOAD_CKSUM_EN to expect a trailing XOR checksum byte
module mnist_img_loader #(
  parameter int IMG_W  = 28,
  parameter int IMG_H  = 28,
  parameter int BYTE_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic [BYTE_W-1:0] data_in,
  input  logic              data_strobe,
  output logic              load_done,
  output logic              busy,
  output logic [6:0]        byte_cnt,
  output logic              overrun,
  output logic              cksum_err,
  input  logic [4:0]        rd_row,
  output logic [IMG_W-1:0]  rd_pixels
);
  localparam int NPIX   = IMG_W * IMG_H;
  localparam int NBYTES = NPIX / BYTE_W;
`ifdef MNIST_LOAD_CKSUM_EN
  localparam int NRX = NBYTES + 1;
`else
  localparam int NRX = NBYTES;
`endif
  localparam logic [6:0] LAST = 7'(NRX - 1);
  typedef enum logic [1:0] {IDLE, RECV, DONE} state_t;
  state_t state_q, state_d;
  logic s1, s2, s3, load_q, accept;
  logic start, abort, inc, wr_img, ck_last, ovr_set;
  logic [NPIX-1:0] buf_q;
  assign accept    = s2 & ~s3;
  assign load_done = state_q == DONE;
  assign busy      = state_q == RECV;
  // two-flop synchronizer plus history flop for strobe edge detection, and load history
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
      load_q <= 1'b0;
    end else begin
      s1 <= data_strobe;
      s2 <= s1;
      s3 <= s2;
      load_q <= load;
    end
  end
  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else state_q <= state_d;
  end
  // next state and datapath strobes; an accept on the abort edge is dropped
  always_comb begin
    state_d = state_q;
    start   = 1'b0;
    abort   = 1'b0;
    inc     = 1'b0;
    wr_img  = 1'b0;
    ck_last = 1'b0;
    ovr_set = 1'b0;
    case (state_q)
      IDLE: begin
        start   = load & ~load_q;
        state_d = start ? RECV : IDLE;
      end
      RECV: begin
        abort = ~load;
        inc   = load & accept;
`ifdef MNIST_LOAD_CKSUM_EN
        ck_last = inc & (byte_cnt == LAST);
        wr_img  = inc & (byte_cnt != LAST);
`else
        wr_img = inc;
`endif
        state_d = abort ? IDLE : (inc && byte_cnt == LAST) ? DONE : RECV;
      end
      DONE: begin
        ovr_set = accept;
        state_d = load ? DONE : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  // byte counter and sticky overrun flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      byte_cnt <= '0;
      overrun  <= 1'b0;
    end else begin
      byte_cnt <= (start || abort) ? '0 : inc ? byte_cnt + 7'd1 : byte_cnt;
      overrun  <= start ? 1'b0 : (overrun | ovr_set);
    end
  end
  // pixel buffer: byte k lands LSB-first at pixels 8k..8k+7; kept across aborts and new loads
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) buf_q <= '0;
    else if (wr_img) buf_q[BYTE_W*int'(byte_cnt) +: BYTE_W] <= data_in;
  end
`ifdef MNIST_LOAD_CKSUM_EN
  logic [BYTE_W-1:0] acc;
  // running XOR of image bytes, compared against the trailing checksum byte
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc       <= '0;
      cksum_err <= 1'b0;
    end else begin
      acc       <= start ? '0 : wr_img ? (acc ^ data_in) : acc;
      cksum_err <= start ? 1'b0 : ck_last ? (acc != data_in) : cksum_err;
    end
  end
`else
  assign cksum_err = 1'b0;
`endif
  logic [IMG_W-1:0] rows [IMG_H];
  for (genvar r = 0; r < IMG_H; r++) begin : g_row
    assign rows[r] = buf_q[r*IMG_W +: IMG_W];
  end
  assign rd_pixels = (32'(rd_row) < IMG_H) ? rows[rd_row] : '0;
endmodule

// File: tb/tb_mnist_img_loader.sv
// tb_mnist_img_loader: checks the image loader against a byte-array model of the load protocol
module tb_mnist_img_loader;
  localparam int IMG_W  = 28;
  localparam int IMG_H  = 28;
  localparam int BYTE_W = 8;
  localparam int NBYTES = IMG_W * IMG_H / BYTE_W;
`ifdef MNIST_LOAD_CKSUM_EN
  localparam int NRX = NBYTES + 1;
`else
  localparam int NRX = NBYTES;
`endif
  logic clk = 1'b0, rst_n = 1'b0, load = 1'b0, data_strobe = 1'b0;
  logic [7:0] data_in = '0;
  logic [4:0] rd_row = '0;
  logic load_done, busy, overrun, cksum_err;
  logic [6:0] byte_cnt;
  logic [IMG_W-1:0] rd_pixels;
  int checks = 0, errors = 0;
  logic [7:0] img_m [NBYTES];
  logic [7:0] pat [NBYTES];
  int m_cnt, m_phase;
  logic m_ovr, m_err;
  logic [7:0] m_acc;
  typedef struct {
    logic [4:0]  row;
    logic [27:0] exp;
  } row_vec_t;
  row_vec_t vec [5];

  always #5 clk = ~clk;

  mnist_img_loader #(.IMG_W(IMG_W), .IMG_H(IMG_H), .BYTE_W(BYTE_W)) dut (
    .clk(clk), .rst_n(rst_n), .load(load), .data_in(data_in), .data_strobe(data_strobe),
    .load_done(load_done), .busy(busy), .byte_cnt(byte_cnt), .overrun(overrun),
    .cksum_err(cksum_err), .rd_row(rd_row), .rd_pixels(rd_pixels)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic model_reset;
    foreach (img_m[i]) img_m[i] = '0;
    m_cnt = 0; m_phase = 0; m_ovr = 0; m_err = 0; m_acc = '0;
  endtask

  // phase 0 idle, 1 receiving, 2 image complete
  task automatic model_accept(input logic [7:0] b);
    if (m_phase == 1) begin
      if (m_cnt < NBYTES) begin
        img_m[m_cnt] = b;
        m_acc ^= b;
      end else m_err = (m_acc != b);
      m_cnt++;
      if (m_cnt == NRX) m_phase = 2;
    end else if (m_phase == 2) m_ovr = 1;
  endtask

  function automatic logic [IMG_W-1:0] mrow(input int r);
    logic [IMG_W-1:0] v = '0;
    for (int j = 0; j < IMG_W; j++) begin
      int p = r * IMG_W + j;
      if (r < IMG_H) v[j] = img_m[p / BYTE_W][p % BYTE_W];
    end
    return v;
  endfunction

  function automatic logic [7:0] pat_xor;
    logic [7:0] x = '0;
    foreach (pat[i]) x ^= pat[i];
    return x;
  endfunction

  task automatic set_load(input logic v);
    logic prev = load;
    load = v;
    tick;
    if (v && !prev && m_phase == 0) begin
      m_phase = 1; m_cnt = 0; m_ovr = 0; m_err = 0; m_acc = '0;
    end else if (!v) begin
      if (m_phase == 1) m_cnt = 0;
      m_phase = 0;
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input int hi);
    data_in = b;
    data_strobe = 1'b1;
    repeat (hi) tick;
    data_strobe = 1'b0;
    repeat (4) tick;
    model_accept(b);
  endtask

  task automatic check_status(input string tag);
    chk({tag, "_byte_cnt"}, 32'(byte_cnt), 32'(m_cnt));
    chk({tag, "_load_done"}, 32'(load_done), 32'(m_phase == 2));
    chk({tag, "_busy"}, 32'(busy), 32'(m_phase == 1));
    chk({tag, "_overrun"}, 32'(overrun), 32'(m_ovr));
    chk({tag, "_cksum_err"}, 32'(cksum_err), 32'(m_err));
  endtask

  task automatic check_rows(input string tag);
    for (int r = 0; r < 32; r++) begin
      rd_row = 5'(r);
      #1;
      chk($sformatf("%s_row%0d", tag, r), 32'(rd_pixels), 32'(mrow(r)));
    end
  endtask

  task automatic send_image(input string tag, input int n, input int hi_max);
    for (int k = 0; k < n; k++) begin
      send_byte((k < NBYTES) ? pat[k] : pat_xor(), $urandom_range(1, hi_max));
      check_status(tag);
    end
  endtask

  initial begin
    vec[0] = '{5'd0,  28'h3020100};
    vec[1] = '{5'd1,  28'h0605040};
    vec[2] = '{5'd27, 28'h61605F5};
    vec[3] = '{5'd28, 28'h0};
    vec[4] = '{5'd31, 28'h0};
    model_reset;
    repeat (2) tick;
    check_status("reset");
    check_rows("reset");
    rst_n = 1'b1;
    tick;

    // counting image with end-of-load latency measured on the final byte
    for (int k = 0; k < NBYTES; k++) pat[k] = 8'(k);
    set_load(1'b1);
    check_status("t1_start");
    for (int k = 0; k < NRX - 1; k++) send_byte(pat[k], 1);
    check_status("t1_pre");
    data_in = (NRX > NBYTES) ? pat_xor() : pat[NBYTES-1];
    data_strobe = 1'b1;
    tick;
    chk("t1_lat_n", 32'(load_done), 32'd0);
    tick;
    chk("t1_lat_n1", 32'(load_done), 32'd0);
    tick;
    chk("t1_lat_n2", 32'(load_done), 32'd1);
    data_strobe = 1'b0;
    repeat (4) tick;
    model_accept(data_in);
    check_status("t1_done");
    chk("t1_byte_cnt", 32'(byte_cnt), 32'(NRX));
    foreach (vec[i]) begin
      rd_row = vec[i].row;
      #1;
      chk($sformatf("t1_vec_row%0d", vec[i].row), 32'(rd_pixels), 32'(vec[i].exp));
    end

    // strobe after completion
    send_byte(8'hFF, 1);
    check_status("t2_ovr");
    chk("t2_overrun", 32'(overrun), 32'd1);
    check_rows("t2");
    load = 1'b0;
    #1;
    chk("t2_done_hold", 32'(load_done), 32'd1);
    set_load(1'b0);
    chk("t2_done_drop", 32'(load_done), 32'd0);
    set_load(1'b1);
    check_status("t2_reload");

    // abort after 40 bytes, then a complete fresh load
    for (int k = 0; k < NBYTES; k++) pat[k] = 8'($urandom);
    send_image("t3_part", 40, 3);
    set_load(1'b0);
    tick;
    check_status("t3_abort");
    check_rows("t3_abort");
    set_load(1'b1);
    for (int k = 0; k < NBYTES; k++) pat[k] = 8'($urandom);
    send_image("t3_full", NRX, 3);
    check_rows("t3_full");

    // long strobe accepted once, then a one-cycle strobe
    set_load(1'b0);
    set_load(1'b1);
    send_byte(8'h3C, 20);
    check_status("t4_long");
    send_byte(8'hC3, 1);
    check_status("t4_short");
    check_rows("t4");

    // asynchronous reset between clock edges
    send_byte(8'h5A, 2);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    load = 1'b0;
    #1;
    model_reset;
    check_status("t5_rst");
    check_rows("t5_rst");
    tick;
    rst_n = 1'b1;
    tick;

    // randomized loads, alternating complete and aborted
    for (int it = 0; it < 4; it++) begin
      int n = (it % 2) ? $urandom_range(1, NRX - 1) : NRX;
      for (int k = 0; k < NBYTES; k++) pat[k] = 8'($urandom);
      set_load(1'b0);
      set_load(1'b1);
      send_image($sformatf("rnd%0d", it), n, 4);
      if (it % 2) begin
        set_load(1'b0);
        check_status($sformatf("rnd%0d_abort", it));
      end
      check_rows($sformatf("rnd%0d", it));
    end

`ifdef MNIST_LOAD_CKSUM_EN
    // good and bad checksum on a constant image
    for (int t = 0; t < 2; t++) begin
      for (int k = 0; k < NBYTES; k++) pat[k] = 8'hA5;
      set_load(1'b0);
      set_load(1'b1);
      send_image($sformatf("t6_img%0d", t), NBYTES, 2);
      send_byte(8'(t), 1);
      check_status($sformatf("t6_ck%0d", t));
      chk($sformatf("t6_err%0d", t), 32'(cksum_err), 32'(t));
      chk($sformatf("t6_cnt%0d", t), 32'(byte_cnt), 32'(NBYTES + 1));
      check_rows($sformatf("t6_%0d", t));
    end
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
